// File: rtl/rename_map_table_pkg.sv
// Shared encodings and types for the speculative rename map table.
package rename_map_table_pkg;

  localparam int LREG_NUM_DEF = 32;
  localparam int LREG_W_DEF   = $clog2(LREG_NUM_DEF);
  localparam int PREG_W_DEF   = 6;

  typedef enum logic [1:0] {
    ROB_STATE_IDLE     = 2'd0,
    ROB_STATE_ROLLBACK = 2'd1,
    ROB_STATE_WALK     = 2'd2
  } rob_state_e;

  typedef logic [LREG_NUM_DEF*PREG_W_DEF-1:0] map_flat_t;

endpackage

// File: rtl/rename_map_table_ckpt_ctrl.sv
// Checkpoint ring bookkeeping for the rename map table: head/tail/count,
// live mask, accept/ready decisions and snapshot write/read strobes.
module rat_ckpt_ctrl #(
  parameter  int NUM_CKPT = 4,
  localparam int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rollback,
  input  logic              restore_ok,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [CKPT_W-1:0] alloc_id,
  input  logic              free_valid,
  input  logic [CKPT_W-1:0] free_id,
  input  logic              restore_valid,
  input  logic [CKPT_W-1:0] restore_id,
  output logic [CKPT_W:0]   count,
  output logic              snap_wr_en,
  output logic [CKPT_W-1:0] snap_wr_id,
  output logic              snap_rd_en,
  output logic [CKPT_W-1:0] snap_rd_id
);

  logic [CKPT_W-1:0]   head_r;
  logic [CKPT_W-1:0]   tail_r;
  logic [CKPT_W:0]     count_r;
  logic [NUM_CKPT-1:0] live_s;
  logic                restore_fire_s;
  logic                alloc_fire_s;
  logic                free_fire_s;

  // A slot is live when its ring distance from head is below count.
  always_comb begin
    live_s = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      live_s[i] = {1'b0, CKPT_W'(i) - head_r} < count_r;
    end
  end

  assign restore_fire_s = restore_valid && restore_ok && !rollback && live_s[restore_id];
  assign alloc_ready    = (count_r != (CKPT_W+1)'(NUM_CKPT)) && !restore_fire_s && !rollback;
  assign alloc_fire_s   = alloc_valid && alloc_ready;
  assign free_fire_s    = free_valid && (count_r != {(CKPT_W+1){1'b0}}) && (free_id == head_r)
                          && !restore_fire_s && !rollback;

  // Ring pointers and occupancy; a restore truncates the ring at the restored slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= {CKPT_W{1'b0}};
      tail_r  <= {CKPT_W{1'b0}};
      count_r <= {(CKPT_W+1){1'b0}};
    end else if (rollback) begin
      head_r  <= {CKPT_W{1'b0}};
      tail_r  <= {CKPT_W{1'b0}};
      count_r <= {(CKPT_W+1){1'b0}};
    end else if (restore_fire_s) begin
      tail_r  <= restore_id;
      count_r <= {1'b0, restore_id - head_r};
    end else begin
      if (alloc_fire_s) tail_r <= tail_r + CKPT_W'(1);
      if (free_fire_s)  head_r <= head_r + CKPT_W'(1);
      case ({alloc_fire_s, free_fire_s})
        2'b10:   count_r <= count_r + (CKPT_W+1)'(1);
        2'b01:   count_r <= count_r - (CKPT_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign alloc_id   = tail_r;
  assign count      = count_r;
  assign snap_wr_en = alloc_fire_s;
  assign snap_wr_id = tail_r;
  assign snap_rd_en = restore_fire_s;
  assign snap_rd_id = restore_id;

endmodule

// File: rtl/rename_map_table.sv
// Speculative register alias table with rollback, walk and per-branch checkpoints.
// Checkpoint storage is built only when RAT_CKPT_EN is defined.
module rename_map_table
  import rename_map_table_pkg::*;
#(
  parameter  int RENAME_WIDTH = 2,
  parameter  int LREG_NUM     = LREG_NUM_DEF,
  parameter  int PREG_W       = PREG_W_DEF,
  parameter  int NUM_CKPT     = 4,
  localparam int LREG_W       = $clog2(LREG_NUM),
  localparam int CKPT_W       = $clog2(NUM_CKPT)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [RENAME_WIDTH-1:0]        rn_lrd_wren,
  input  logic [RENAME_WIDTH*LREG_W-1:0] rn_lrd_wraddr,
  input  logic [RENAME_WIDTH*PREG_W-1:0] rn_lrd_wrdata,
  input  logic [RENAME_WIDTH-1:0]        rn_lrs1_rden,
  input  logic [RENAME_WIDTH-1:0]        rn_lrs2_rden,
  input  logic [RENAME_WIDTH-1:0]        rn_lrd_rden,
  input  logic [RENAME_WIDTH*LREG_W-1:0] rn_lrs1,
  input  logic [RENAME_WIDTH*LREG_W-1:0] rn_lrs2,
  input  logic [RENAME_WIDTH*LREG_W-1:0] rn_lrd,
  output logic [RENAME_WIDTH*PREG_W-1:0] rat_prs1,
  output logic [RENAME_WIDTH*PREG_W-1:0] rat_prs2,
  output logic [RENAME_WIDTH*PREG_W-1:0] rat_prd,
  input  logic [1:0]                     rob_state,
  input  logic [RENAME_WIDTH-1:0]        walk_valid,
  input  logic [RENAME_WIDTH*LREG_W-1:0] walk_lrd,
  input  logic [RENAME_WIDTH*PREG_W-1:0] walk_prd,
  input  logic [LREG_NUM*PREG_W-1:0]     arch_rat_flat,
  input  logic                           ckpt_alloc_valid,
  output logic                           ckpt_alloc_ready,
  output logic [CKPT_W-1:0]              ckpt_alloc_id,
  input  logic                           ckpt_free_valid,
  input  logic [CKPT_W-1:0]              ckpt_free_id,
  input  logic                           ckpt_restore_valid,
  input  logic [CKPT_W-1:0]              ckpt_restore_id,
  output logic [CKPT_W:0]                ckpt_count
);

  logic [PREG_W-1:0] table_r     [LREG_NUM];
  logic [PREG_W-1:0] table_nxt_s [LREG_NUM];
  logic              is_rollback_s;
  logic              is_walk_s;
  logic              is_idle_s;

  assign is_rollback_s = (rob_state == ROB_STATE_ROLLBACK);
  assign is_walk_s     = (rob_state == ROB_STATE_WALK);
  assign is_idle_s     = (rob_state == ROB_STATE_IDLE);

`ifdef RAT_CKPT_EN
  logic [PREG_W-1:0] snap_r [NUM_CKPT][LREG_NUM];
  logic              snap_wr_en_s;
  logic [CKPT_W-1:0] snap_wr_id_s;
  logic              snap_rd_en_s;
  logic [CKPT_W-1:0] snap_rd_id_s;

  rat_ckpt_ctrl #(.NUM_CKPT(NUM_CKPT)) u_ckpt_ctrl (
    .clock         (clock),
    .reset_n       (reset_n),
    .rollback      (is_rollback_s),
    .restore_ok    (is_idle_s),
    .alloc_valid   (ckpt_alloc_valid),
    .alloc_ready   (ckpt_alloc_ready),
    .alloc_id      (ckpt_alloc_id),
    .free_valid    (ckpt_free_valid),
    .free_id       (ckpt_free_id),
    .restore_valid (ckpt_restore_valid),
    .restore_id    (ckpt_restore_id),
    .count         (ckpt_count),
    .snap_wr_en    (snap_wr_en_s),
    .snap_wr_id    (snap_wr_id_s),
    .snap_rd_en    (snap_rd_en_s),
    .snap_rd_id    (snap_rd_id_s)
  );

  // Snapshot captures the table as it will look after this cycle's update.
  always_ff @(posedge clock) begin
    if (snap_wr_en_s) snap_r[snap_wr_id_s] <= table_nxt_s;
  end
`else
  logic unused_ckpt_s;
  assign unused_ckpt_s    = ^{ckpt_alloc_valid, ckpt_free_valid, ckpt_free_id,
                              ckpt_restore_valid, ckpt_restore_id};
  assign ckpt_alloc_ready = 1'b0;
  assign ckpt_alloc_id    = {CKPT_W{1'b0}};
  assign ckpt_count       = {(CKPT_W+1){1'b0}};
`endif

  // Next table: one source per cycle; later slots overwrite earlier ones.
  always_comb begin
    table_nxt_s = table_r;
    if (is_rollback_s) begin
      for (int i = 0; i < LREG_NUM; i++) table_nxt_s[i] = arch_rat_flat[i*PREG_W +: PREG_W];
    end
`ifdef RAT_CKPT_EN
    else if (snap_rd_en_s) begin
      table_nxt_s = snap_r[snap_rd_id_s];
    end
`endif
    else if (is_walk_s) begin
      for (int k = 0; k < RENAME_WIDTH; k++)
        table_nxt_s[walk_lrd[k*LREG_W +: LREG_W]] = walk_valid[k] ?
          walk_prd[k*PREG_W +: PREG_W] : table_nxt_s[walk_lrd[k*LREG_W +: LREG_W]];
    end else if (is_idle_s) begin
      for (int k = 0; k < RENAME_WIDTH; k++)
        table_nxt_s[rn_lrd_wraddr[k*LREG_W +: LREG_W]] = rn_lrd_wren[k] ?
          rn_lrd_wrdata[k*PREG_W +: PREG_W] : table_nxt_s[rn_lrd_wraddr[k*LREG_W +: LREG_W]];
    end else begin
      table_nxt_s = table_r;
    end
  end

  // Map table register; reset maps every logical register to its own index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LREG_NUM; i++) table_r[i] <= PREG_W'(i);
    end else begin
      table_r <= table_nxt_s;
    end
  end

  function automatic logic [PREG_W-1:0] lookup(input logic [LREG_W-1:0] addr, input int slot);
    logic [PREG_W-1:0] v;
    v = table_r[addr];
    for (int j = 0; j < slot; j++)
      v = (rn_lrd_wren[j] && (rn_lrd_wraddr[j*LREG_W +: LREG_W] == addr)) ?
          rn_lrd_wrdata[j*PREG_W +: PREG_W] : v;
    return v;
  endfunction

  // Read ports with intra-group bypass from older rename slots.
  always_comb begin
    rat_prs1 = '0;
    rat_prs2 = '0;
    rat_prd  = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      rat_prs1[k*PREG_W +: PREG_W] = rn_lrs1_rden[k] ? lookup(rn_lrs1[k*LREG_W +: LREG_W], k) : PREG_W'(0);
      rat_prs2[k*PREG_W +: PREG_W] = rn_lrs2_rden[k] ? lookup(rn_lrs2[k*LREG_W +: LREG_W], k) : PREG_W'(0);
      rat_prd[k*PREG_W +: PREG_W]  = rn_lrd_rden[k]  ? lookup(rn_lrd[k*LREG_W +: LREG_W], k)  : PREG_W'(0);
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: read/bypass vector table plus
// hand-written checkpoint, rollback, walk and reset sequences.
module tb_rename_map_table;
  import rename_map_table_pkg::*;

  localparam int RW = 2;
  localparam int LN = 32;
  localparam int PW = 6;
  localparam int NC = 4;
  localparam int LW = 5;
  localparam int CW = 2;

  logic             clock;
  logic             reset_n;
  logic [RW-1:0]    rn_lrd_wren;
  logic [RW*LW-1:0] rn_lrd_wraddr;
  logic [RW*PW-1:0] rn_lrd_wrdata;
  logic [RW-1:0]    rn_lrs1_rden, rn_lrs2_rden, rn_lrd_rden;
  logic [RW*LW-1:0] rn_lrs1, rn_lrs2, rn_lrd;
  logic [RW*PW-1:0] rat_prs1, rat_prs2, rat_prd;
  logic [1:0]       rob_state;
  logic [RW-1:0]    walk_valid;
  logic [RW*LW-1:0] walk_lrd;
  logic [RW*PW-1:0] walk_prd;
  map_flat_t        arch_rat_flat;
  logic             ckpt_alloc_valid, ckpt_alloc_ready;
  logic [CW-1:0]    ckpt_alloc_id;
  logic             ckpt_free_valid;
  logic [CW-1:0]    ckpt_free_id;
  logic             ckpt_restore_valid;
  logic [CW-1:0]    ckpt_restore_id;
  logic [CW:0]      ckpt_count;

  rename_map_table #(.RENAME_WIDTH(RW), .LREG_NUM(LN), .PREG_W(PW), .NUM_CKPT(NC)) dut (
    .clock(clock), .reset_n(reset_n),
    .rn_lrd_wren(rn_lrd_wren), .rn_lrd_wraddr(rn_lrd_wraddr), .rn_lrd_wrdata(rn_lrd_wrdata),
    .rn_lrs1_rden(rn_lrs1_rden), .rn_lrs2_rden(rn_lrs2_rden), .rn_lrd_rden(rn_lrd_rden),
    .rn_lrs1(rn_lrs1), .rn_lrs2(rn_lrs2), .rn_lrd(rn_lrd),
    .rat_prs1(rat_prs1), .rat_prs2(rat_prs2), .rat_prd(rat_prd),
    .rob_state(rob_state), .walk_valid(walk_valid), .walk_lrd(walk_lrd), .walk_prd(walk_prd),
    .arch_rat_flat(arch_rat_flat),
    .ckpt_alloc_valid(ckpt_alloc_valid), .ckpt_alloc_ready(ckpt_alloc_ready),
    .ckpt_alloc_id(ckpt_alloc_id), .ckpt_free_valid(ckpt_free_valid),
    .ckpt_free_id(ckpt_free_id), .ckpt_restore_valid(ckpt_restore_valid),
    .ckpt_restore_id(ckpt_restore_id), .ckpt_count(ckpt_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [1:0] wren;
    logic [4:0] wa0;
    logic [5:0] wd0;
    logic [4:0] wa1;
    logic [5:0] wd1;
    logic [4:0] rs1_0;
    logic [4:0] rs2_1;
    logic [4:0] rd_1;
    logic [2:0] rden;
    int         e_s1;
    int         e_s2;
    int         e_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_sb(input string nm, input int act);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0d", nm, act);
    end else begin
      e = exp_q.pop_front();
      check(nm, act, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear();
    rn_lrd_wren = '0; rn_lrd_wraddr = '0; rn_lrd_wrdata = '0;
    rn_lrs1_rden = '0; rn_lrs2_rden = '0; rn_lrd_rden = '0;
    rn_lrs1 = '0; rn_lrs2 = '0; rn_lrd = '0;
    rob_state = ROB_STATE_IDLE;
    walk_valid = '0; walk_lrd = '0; walk_prd = '0;
    ckpt_alloc_valid = 1'b0; ckpt_free_valid = 1'b0; ckpt_free_id = '0;
    ckpt_restore_valid = 1'b0; ckpt_restore_id = '0;
  endtask

  task automatic set_arch_identity();
    for (int i = 0; i < LN; i++) arch_rat_flat[i*PW +: PW] = PW'(i);
  endtask

  // Read one logical register through slot 0 (never bypassed).
  task automatic rd(input string nm, input int r, input int exp);
    rn_lrs1 = '0;
    rn_lrs1[LW-1:0] = LW'(r);
    rn_lrs1_rden = 2'b01;
    exp_q.push_back(exp);
    #1;
    check_sb(nm, int'(rat_prs1[PW-1:0]));
    rn_lrs1_rden = 2'b00;
  endtask

  task automatic ren(input int a, input int d);
    rn_lrd_wren = 2'b01;
    rn_lrd_wraddr = {5'd0, LW'(a)};
    rn_lrd_wrdata = {6'd0, PW'(d)};
  endtask

  initial begin
    vecs[0] = '{2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  5'd5, 5'd31, 5'd0, 3'b111,  5, 31,  0};
    vecs[1] = '{2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  5'd5, 5'd31, 5'd0, 3'b000,  0,  0,  0};
    vecs[2] = '{2'b01, 5'd3, 6'd40, 5'd0, 6'd0,  5'd3, 5'd3,  5'd3, 3'b111,  3, 40, 40};
    vecs[3] = '{2'b11, 5'd7, 6'd41, 5'd7, 6'd42, 5'd3, 5'd7,  5'd7, 3'b111, 40, 41, 41};
    vecs[4] = '{2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  5'd7, 5'd3,  5'd1, 3'b111, 42, 40,  1};
    vecs[5] = '{2'b10, 5'd0, 6'd0,  5'd9, 6'd50, 5'd9, 5'd9,  5'd9, 3'b111,  9,  9,  9};
    vecs[6] = '{2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  5'd9, 5'd0,  5'd31, 3'b101, 50, 0, 31};

    clear();
    set_arch_identity();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check("reset_count", int'(ckpt_count), 0);
    check("reset_alloc_id", int'(ckpt_alloc_id), 0);
`ifdef RAT_CKPT_EN
    check("reset_ready", int'(ckpt_alloc_ready), 1);
`else
    check("reset_ready", int'(ckpt_alloc_ready), 0);
`endif
    tick();

    for (int i = 0; i < 7; i++) begin
      clear();
      rn_lrd_wren   = vecs[i].wren;
      rn_lrd_wraddr = {vecs[i].wa1, vecs[i].wa0};
      rn_lrd_wrdata = {vecs[i].wd1, vecs[i].wd0};
      rn_lrs1       = {5'd0, vecs[i].rs1_0};
      rn_lrs2       = {vecs[i].rs2_1, 5'd0};
      rn_lrd        = {vecs[i].rd_1, 5'd0};
      rn_lrs1_rden  = {1'b0, vecs[i].rden[0]};
      rn_lrs2_rden  = {vecs[i].rden[1], 1'b0};
      rn_lrd_rden   = {vecs[i].rden[2], 1'b0};
      exp_q.push_back(vecs[i].e_s1);
      exp_q.push_back(vecs[i].e_s2);
      exp_q.push_back(vecs[i].e_rd);
      #2;
      check_sb($sformatf("vec%0d_prs1_s0", i), int'(rat_prs1[PW-1:0]));
      check_sb($sformatf("vec%0d_prs2_s1", i), int'(rat_prs2[2*PW-1:PW]));
      check_sb($sformatf("vec%0d_prd_s1", i),  int'(rat_prd[2*PW-1:PW]));
      tick();
    end
    clear();

`ifdef RAT_CKPT_EN
    // Allocate two checkpoints, then restore the younger and older ones.
    ckpt_alloc_valid = 1'b1; ren(3, 45);
    tick(); clear();
    check("a1_count", int'(ckpt_count), 1);
    check("a1_alloc_id", int'(ckpt_alloc_id), 1);
    ckpt_alloc_valid = 1'b1; ren(3, 55);
    tick(); clear();
    ren(3, 2);
    tick(); clear();
    rd("r3_after_rename", 3, 2);
    ckpt_restore_valid = 1'b1; ckpt_restore_id = 2'd1;
    tick(); clear();
    rd("r3_restore1", 3, 55);
    check("restore1_count", int'(ckpt_count), 1);
    check("restore1_alloc_id", int'(ckpt_alloc_id), 1);
    ckpt_restore_valid = 1'b1; ckpt_restore_id = 2'd0;
    tick(); clear();
    rd("r3_restore0", 3, 45);
    check("restore0_count", int'(ckpt_count), 0);
    ckpt_restore_valid = 1'b1; ckpt_restore_id = 2'd0;
    tick(); clear();
    rd("r3_restore_dead", 3, 45);
    check("restore_dead_count", int'(ckpt_count), 0);

    // Fill the ring, overflow, free out of order, then wrap.
    for (int i = 0; i < NC; i++) begin
      check($sformatf("fill%0d_alloc_id", i), int'(ckpt_alloc_id), i);
      ckpt_alloc_valid = 1'b1;
      tick(); clear();
    end
    check("full_count", int'(ckpt_count), 4);
    check("full_ready", int'(ckpt_alloc_ready), 0);
    ckpt_alloc_valid = 1'b1;
    tick(); clear();
    check("drop_count", int'(ckpt_count), 4);
    ckpt_free_valid = 1'b1; ckpt_free_id = 2'd1;
    tick(); clear();
    check("free_nonhead_count", int'(ckpt_count), 4);
    ckpt_free_valid = 1'b1; ckpt_free_id = 2'd0;
    tick(); clear();
    check("free0_count", int'(ckpt_count), 3);
    check("free0_ready", int'(ckpt_alloc_ready), 1);
    check("wrap_alloc_id", int'(ckpt_alloc_id), 0);
    ckpt_alloc_valid = 1'b1; ren(3, 33);
    tick(); clear();
    check("wrap_count", int'(ckpt_count), 4);
    ckpt_free_valid = 1'b1; ckpt_free_id = 2'd1;
    tick(); clear();
    ckpt_alloc_valid = 1'b1; ckpt_free_valid = 1'b1; ckpt_free_id = 2'd2; ren(3, 34);
    tick(); clear();
    check("allocfree_count", int'(ckpt_count), 3);
    check("allocfree_alloc_id", int'(ckpt_alloc_id), 2);
    rd("r3_before_wrap_restore", 3, 34);
    ckpt_restore_valid = 1'b1; ckpt_restore_id = 2'd0;
    tick(); clear();
    rd("r3_wrap_restore", 3, 33);
    check("wrap_restore_count", int'(ckpt_count), 1);
    check("wrap_restore_alloc_id", int'(ckpt_alloc_id), 0);
`else
    // Checkpoint requests have no effect without checkpoint storage.
    ckpt_alloc_valid = 1'b1;
    ckpt_free_valid = 1'b1; ckpt_free_id = 2'd0;
    ckpt_restore_valid = 1'b1; ckpt_restore_id = 2'd0;
    tick(); clear();
    rd("nockpt_r3", 3, 40);
    rd("nockpt_r7", 7, 42);
    check("nockpt_count", int'(ckpt_count), 0);
    check("nockpt_ready", int'(ckpt_alloc_ready), 0);
    check("nockpt_alloc_id", int'(ckpt_alloc_id), 0);
`endif

    // Rollback to the architectural map; a concurrent rename is ignored.
    arch_rat_flat[3*PW +: PW] = 6'd12;
    rob_state = ROB_STATE_ROLLBACK;
    ren(5, 60);
    #1;
    check("rollback_ready", int'(ckpt_alloc_ready), 0);
    tick(); clear();
    set_arch_identity();
    rd("rollback_r3", 3, 12);
    rd("rollback_r7", 7, 7);
    rd("rollback_r5", 5, 5);
    check("rollback_count", int'(ckpt_count), 0);

    // Walk replay: youngest duplicate wins, rename ignored, invalid slot skipped.
    rob_state = ROB_STATE_WALK;
    walk_valid = 2'b11;
    walk_lrd = {5'd3, 5'd3};
    walk_prd = {6'd21, 6'd20};
    ren(5, 60);
    tick(); clear();
    rd("walk_r3", 3, 21);
    rd("walk_r5", 5, 5);
    rob_state = ROB_STATE_WALK;
    walk_valid = 2'b10;
    walk_lrd = {5'd8, 5'd6};
    walk_prd = {6'd22, 6'd23};
    tick(); clear();
    rd("walk_r8", 8, 22);
    rd("walk_r6", 6, 6);

    // Asynchronous reset between clock edges.
    #2 reset_n = 1'b0;
    #1;
    rd("async_reset_r3", 3, 3);
    rd("async_reset_r8", 8, 8);
    check("async_reset_count", int'(ckpt_count), 0);
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
